// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift window.
// Optional macro WINDOW_COORD_EN adds centre_row/centre_col outputs.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [7:0] out5,
    output logic [7:0] out6,
    output logic [7:0] out7,
    output logic [7:0] out8,
    output logic [7:0] out9,
    output logic       window_valid,
`ifdef WINDOW_COORD_EN
    output logic [$clog2(IMG_WIDTH)-1:0]  centre_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] centre_row,
`endif
    output logic       frame_done
);

    localparam int DATA_W = 8;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              last_col;
    logic              last_row;
    logic              interior;

    logic [DATA_W-1:0] lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] col_top;
    logic [DATA_W-1:0] col_mid;

    logic [DATA_W-1:0] win_p1 [9];
    logic              vld_p1;
    logic              done_p1;

    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));
    // Centres on the first two columns would straddle the previous line's tail.
    assign interior = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    assign col_top = lb0[col];
    assign col_mid = lb1[col];

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pixel_in_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Line buffers carry no reset; stale lines are masked by the row >= 2 gate.
    always_ff @(posedge clk) begin
        if (pixel_in_valid) begin
            lb0[col] <= col_mid;
            lb1[col] <= pixel_in;
        end
    end

    // Stage p1: window shift plus registered strobes, one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) win_p1[i] <= '0;
        end else if (pixel_in_valid) begin
            win_p1[0] <= win_p1[1];
            win_p1[1] <= win_p1[2];
            win_p1[2] <= col_top;
            win_p1[3] <= win_p1[4];
            win_p1[4] <= win_p1[5];
            win_p1[5] <= col_mid;
            win_p1[6] <= win_p1[7];
            win_p1[7] <= win_p1[8];
            win_p1[8] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= pixel_in_valid && interior;
            done_p1 <= pixel_in_valid && last_row && last_col;
        end
    end

`ifdef WINDOW_COORD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            centre_col <= '0;
            centre_row <= '0;
        end else if (pixel_in_valid && interior) begin
            centre_col <= col - COL_W'(1);
            centre_row <= row - ROW_W'(1);
        end
    end
`endif

    assign out1         = win_p1[0];
    assign out2         = win_p1[1];
    assign out3         = win_p1[2];
    assign out4         = win_p1[3];
    assign out5         = win_p1[4];
    assign out6         = win_p1[5];
    assign out7         = win_p1[6];
    assign out8         = win_p1[7];
    assign out9         = win_p1[8];
    assign window_valid = vld_p1;
    assign frame_done   = done_p1;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 5x4 frame with pixel = row*16+col.
// Define WINDOW_COORD_EN for both files to also check centre_row/centre_col.
module tb_window_3x3_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_in;
    logic       pixel_in_valid;
    logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
    logic       window_valid;
    logic       frame_done;
`ifdef WINDOW_COORD_EN
    logic [2:0] centre_col;
    logic [1:0] centre_row;
`endif
    logic [71:0] win;

    typedef struct {
        logic [71:0] win;
        bit          fd;
        int          r;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
        .out6(out6), .out7(out7), .out8(out8), .out9(out9),
        .window_valid(window_valid),
`ifdef WINDOW_COORD_EN
        .centre_col(centre_col), .centre_row(centre_row),
`endif
        .frame_done(frame_done)
    );

    assign win = {out1, out2, out3, out4, out5, out6, out7, out8, out9};

    always #5 clk = ~clk;

    // Expected window whose newest pixel is (r,c): rows r-2..r, cols c-2..c.
    function automatic logic [71:0] mkwin(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], 8'((r - 2 + i) * 16 + (c - 2 + j))};
        return w;
    endfunction

    // Drive one cycle; push the expected window when an interior pixel is accepted.
    task automatic drive(input bit v, input int r, input int c);
        exp_t e;
        pixel_in_valid = v;
        pixel_in       = v ? 8'(r * 16 + c) : 8'hA5;
        if (v && r >= 2 && c >= 2) begin
            e.win = mkwin(r, c);
            e.fd  = (r == H - 1) && (c == W - 1);
            e.r   = r;
            e.c   = c;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (window_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", window_valid); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
        total++;
        if (win !== 72'h0) begin bad++; $display("FAIL reset_window got=%h want=0", win); end
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        exp_t e;
        int ns = 0, nf = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, r, c);
                total++;
                if (window_valid !== (exp_q.size() != 0)) begin
                    bad++; $display("FAIL first_valid px=%0d,%0d got=%b want=%b", r, c, window_valid, exp_q.size() != 0);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if (win !== e.win) begin bad++; $display("FAIL first_window px=%0d,%0d got=%h want=%h", r, c, win, e.win); end
                    total++;
                    if (frame_done !== e.fd) begin bad++; $display("FAIL first_done px=%0d,%0d got=%b want=%b", r, c, frame_done, e.fd); end
`ifdef WINDOW_COORD_EN
                    total++;
                    if ({centre_row, centre_col} !== {2'(e.r - 1), 3'(e.c - 1)}) begin
                        bad++; $display("FAIL first_coord got=%0d,%0d want=%0d,%0d", centre_row, centre_col, e.r - 1, e.c - 1);
                    end
`endif
                end else begin
                    total++;
                    if (frame_done !== 1'b0) begin bad++; $display("FAIL first_done_idle px=%0d,%0d got=%b want=0", r, c, frame_done); end
                end
                if (window_valid === 1'b1) ns++;
                if (frame_done === 1'b1) nf++;
                if (r == 2 && c == 2) begin
                    total++;
                    if (win !== 72'h00_01_02_10_11_12_20_21_22) begin bad++; $display("FAIL first_win22 got=%h want=000102101112202122", win); end
                end
                if (r == 3 && c == 2) begin
                    total++;
                    if (win !== 72'h10_11_12_20_21_22_30_31_32) begin bad++; $display("FAIL line_wrap_win32 got=%h want=101112202122303132", win); end
                end
                if (r == 3 && c == 4) begin
                    total++;
                    if ({window_valid, frame_done, out5, out9} !== {2'b11, 8'h23, 8'h34}) begin
                        bad++; $display("FAIL last_win got=%b%b %h %h want=11 23 34", window_valid, frame_done, out5, out9);
                    end
                end
            end
        end
        total++;
        if (ns !== 6) begin bad++; $display("FAIL first_strobes got=%0d want=6", ns); end
        total++;
        if (nf !== 1) begin bad++; $display("FAIL first_frame_done got=%0d want=1", nf); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [71:0] prev;
        int ns = 0, nf = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    while ($urandom_range(1, 0) == 1) begin
                        prev = win;
                        drive(1'b0, r, c);
                        total++;
                        if ({window_valid, frame_done, win} !== {2'b00, prev}) begin
                            bad++; $display("FAIL gap_hold px=%0d,%0d got=%b%b %h want=00 %h", r, c, window_valid, frame_done, win, prev);
                        end
                    end
                    drive(1'b1, r, c);
                    total++;
                    if (window_valid !== (exp_q.size() != 0)) begin
                        bad++; $display("FAIL gap_valid px=%0d,%0d got=%b want=%b", r, c, window_valid, exp_q.size() != 0);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        total++;
                        if (win !== e.win) begin bad++; $display("FAIL gap_window px=%0d,%0d got=%h want=%h", r, c, win, e.win); end
                        total++;
                        if (frame_done !== e.fd) begin bad++; $display("FAIL gap_done px=%0d,%0d got=%b want=%b", r, c, frame_done, e.fd); end
`ifdef WINDOW_COORD_EN
                        total++;
                        if ({centre_row, centre_col} !== {2'(e.r - 1), 3'(e.c - 1)}) begin
                            bad++; $display("FAIL gap_coord got=%0d,%0d want=%0d,%0d", centre_row, centre_col, e.r - 1, e.c - 1);
                        end
`endif
                    end else begin
                        total++;
                        if (frame_done !== 1'b0) begin bad++; $display("FAIL gap_done_idle px=%0d,%0d got=%b want=0", r, c, frame_done); end
                    end
                    if (window_valid === 1'b1) ns++;
                    if (frame_done === 1'b1) nf++;
                end
            end
        end
        total++;
        if (ns !== 12) begin bad++; $display("FAIL gap_strobes got=%0d want=12", ns); end
        total++;
        if (nf !== 2) begin bad++; $display("FAIL gap_frame_done got=%0d want=2", nf); end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int ns = 0;
        // Partial frame up to pixel 0x21: no interior pixel yet, so no strobe.
        for (int k = 0; k <= 2 * W + 1; k++) begin
            drive(1'b1, k / W, k % W);
            total++;
            if (window_valid !== 1'b0) begin bad++; $display("FAIL pre_rst_valid k=%0d got=%b want=0", k, window_valid); end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({window_valid, frame_done} !== 2'b00) begin
            bad++; $display("FAIL after_rst got=%b%b want=00", window_valid, frame_done);
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, r, c);
                total++;
                if (window_valid !== (exp_q.size() != 0)) begin
                    bad++; $display("FAIL rst_valid px=%0d,%0d got=%b want=%b", r, c, window_valid, exp_q.size() != 0);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({win, frame_done} !== {e.win, e.fd}) begin
                        bad++; $display("FAIL rst_window px=%0d,%0d got=%h/%b want=%h/%b", r, c, win, frame_done, e.win, e.fd);
                    end
                end
                if (window_valid === 1'b1) ns++;
                if (r == 2 && c == 2) begin
                    total++;
                    if (win !== 72'h00_01_02_10_11_12_20_21_22) begin bad++; $display("FAIL rst_first_win got=%h want=000102101112202122", win); end
                end
            end
        end
        total++;
        if (ns !== 6) begin bad++; $display("FAIL rst_strobes got=%0d want=6", ns); end
    endtask

    initial begin
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in = 8'h00;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_mid_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
